// File: rtl/ddr2_init_seq.sv
// ddr2_init_seq - JEDEC DDR2 power-up initialisation sequencer.
// Drives the DFI control fields from reset release through the complete
// init sequence (CKE wait, PRECHARGE ALL, EMRS2/3/1, MRS with DLL reset,
// refreshes, OCD default/exit), then raises init_done and parks on NOP.
// Optional build macro: DDR2_INIT_FAST_SIM_EN (shortens T_PWRUP/T_NOP/T_DLL
// to 16/4/8 cycles for simulation; all other spacings unchanged).

`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 1
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module ddr2_init_seq #(
    parameter int unsigned T_PWRUP    = 32'd40000,
    parameter int unsigned T_NOP      = 32'd80,
    parameter int unsigned T_RP       = 32'd3,
    parameter int unsigned T_MRD      = 32'd2,
    parameter int unsigned T_RFC      = 32'd26,
    parameter int unsigned T_DLL      = 32'd200,
    parameter logic [12:0] MR_VALUE   = 13'h0442,
    parameter logic [12:0] EMR1_VALUE = 13'h0004
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        cke,
    output logic [`DRAM_CS_WIDTH-1:0]   cs_n,
    output logic                        ras_n,
    output logic                        cas_n,
    output logic                        we_n,
    output logic [`DRAM_BA_WIDTH-1:0]   ba,
    output logic [`DRAM_ADDR_WIDTH-1:0] addr,
    output logic                        odt,
    output logic                        init_done,
    output logic                        init_busy
);

    localparam int CS_W   = `DRAM_CS_WIDTH;
    localparam int BA_W   = `DRAM_BA_WIDTH;
    localparam int ADDR_W = `DRAM_ADDR_WIDTH;

    // Raw timing values; the fast-sim build shortens only the long waits.
`ifdef DDR2_INIT_FAST_SIM_EN
    localparam int unsigned RAW_PWRUP = 32'd16;
    localparam int unsigned RAW_NOP   = 32'd4;
    localparam int unsigned RAW_DLL   = 32'd8;
`else
    localparam int unsigned RAW_PWRUP = T_PWRUP;
    localparam int unsigned RAW_NOP   = T_NOP;
    localparam int unsigned RAW_DLL   = T_DLL;
`endif

    // A spacing of zero would mean "same cycle", which cannot happen: clamp to one.
    function automatic int unsigned clamp1(input int unsigned v);
        if (v == 32'd0) begin
            return 32'd1;
        end else begin
            return v;
        end
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    localparam int unsigned EFF_PWRUP = clamp1(RAW_PWRUP);
    localparam int unsigned EFF_NOP   = clamp1(RAW_NOP);
    localparam int unsigned EFF_RP    = clamp1(T_RP);
    localparam int unsigned EFF_MRD   = clamp1(T_MRD);
    localparam int unsigned EFF_RFC   = clamp1(T_RFC);
    localparam int unsigned EFF_DLL   = clamp1(RAW_DLL);

    localparam int unsigned MAX_T = max_u(max_u(max_u(EFF_PWRUP, EFF_NOP), max_u(EFF_RP, EFF_MRD)), EFF_RFC);
    localparam int CNT_W = $clog2(MAX_T + 32'd1);
    localparam int DLL_W = $clog2(EFF_DLL + 32'd1);

    // Counters hold "cycles remaining minus one": zero means the next edge may issue.
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(EFF_PWRUP - 32'd1);
    localparam logic [CNT_W-1:0] LD_NOP   = CNT_W'(EFF_NOP - 32'd1);
    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(EFF_RP - 32'd1);
    localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(EFF_MRD - 32'd1);
    localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(EFF_RFC - 32'd1);
    localparam logic [DLL_W-1:0] LD_DLL   = DLL_W'(EFF_DLL - 32'd1);

    // Command encodings {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // Address patterns for the mode-register writes.
    localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A8_BIT   = ONE_A << 4'd8;
    localparam logic [ADDR_W-1:0] A10_BIT  = ONE_A << 4'd10;
    localparam logic [ADDR_W-1:0] OCD_MASK = (ONE_A << 4'd7) | (ONE_A << 4'd8) | (ONE_A << 4'd9);
    localparam logic [ADDR_W-1:0] MR_BASE  = ADDR_W'(MR_VALUE);
    localparam logic [ADDR_W-1:0] EMR_BASE = ADDR_W'(EMR1_VALUE);
    localparam logic [ADDR_W-1:0] ADDR_MR_DLLRST = MR_BASE | A8_BIT;
    localparam logic [ADDR_W-1:0] ADDR_MR_NORMAL = MR_BASE & ~A8_BIT;
    localparam logic [ADDR_W-1:0] ADDR_EMR_OCDX  = EMR_BASE & ~OCD_MASK;
    localparam logic [ADDR_W-1:0] ADDR_EMR_OCDD  = (EMR_BASE & ~OCD_MASK) | OCD_MASK;

    localparam logic [BA_W-1:0] BA_0 = BA_W'(2'd0);
    localparam logic [BA_W-1:0] BA_1 = BA_W'(2'd1);
    localparam logic [BA_W-1:0] BA_2 = BA_W'(2'd2);
    localparam logic [BA_W-1:0] BA_3 = BA_W'(2'd3);

    // Each command state means "waiting to issue this command".
    typedef enum logic [4:0] {
        S_IDLE         = 5'd0,
        S_WAIT_PWRUP   = 5'd1,
        S_CKE_HIGH     = 5'd2,
        S_EMRS2        = 5'd3,
        S_EMRS3        = 5'd4,
        S_EMRS1        = 5'd5,
        S_MRS_DLLRST   = 5'd6,
        S_PRE2         = 5'd7,
        S_REF1         = 5'd8,
        S_REF2         = 5'd9,
        S_MRS          = 5'd10,
        S_OCD_DEF      = 5'd11,
        S_OCD_EXIT     = 5'd12,
        S_DONE_WAIT    = 5'd13,
        S_DONE         = 5'd14
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DLL_W-1:0]    r_dll;
    logic                r_cke;
    logic [3:0]          r_cmd;
    logic [BA_W-1:0]     r_ba;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_odt;
    logic                r_done;
    logic                r_busy;

    logic                w_cnt_zero;
    logic                w_dll_zero;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_dll_zero = (r_dll == '0);

    // Sequencer: state, spacing/DLL down-counters and every registered DFI output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dll   <= '0;
            r_cke   <= 1'b0;
            r_cmd   <= CMD_DESEL;
            r_ba    <= '0;
            r_addr  <= '0;
            r_odt   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Defaults: NOP on the bus, both counters count down and stick at zero.
            r_cmd  <= CMD_NOP;
            r_ba   <= '0;
            r_addr <= '0;
            r_odt  <= 1'b0;
            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (!w_dll_zero) begin
                r_dll <= r_dll - 1'b1;
            end else begin
                r_dll <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cke   <= 1'b0;
                    r_cmd   <= CMD_DESEL;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_cnt   <= LD_PWRUP;
                    r_state <= S_WAIT_PWRUP;
                end
                S_WAIT_PWRUP: begin
                    if (w_cnt_zero) begin
                        r_cke   <= 1'b1;
                        r_cnt   <= LD_NOP;
                        r_state <= S_CKE_HIGH;
                    end else begin
                        r_cmd <= CMD_DESEL;
                    end
                end
                S_CKE_HIGH: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_PRE;
                        r_addr  <= A10_BIT;
                        r_cnt   <= LD_RP;
                        r_state <= S_EMRS2;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_EMRS2: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_MRS;
                        r_ba    <= BA_2;
                        r_cnt   <= LD_MRD;
                        r_state <= S_EMRS3;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_EMRS3: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_MRS;
                        r_ba    <= BA_3;
                        r_cnt   <= LD_MRD;
                        r_state <= S_EMRS1;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_EMRS1: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_MRS;
                        r_ba    <= BA_1;
                        r_addr  <= ADDR_EMR_OCDX;
                        r_cnt   <= LD_MRD;
                        r_state <= S_MRS_DLLRST;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_MRS_DLLRST: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_MRS;
                        r_ba    <= BA_0;
                        r_addr  <= ADDR_MR_DLLRST;
                        r_cnt   <= LD_MRD;
                        r_dll   <= LD_DLL;
                        r_state <= S_PRE2;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_PRE2: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_PRE;
                        r_addr  <= A10_BIT;
                        r_cnt   <= LD_RP;
                        r_state <= S_REF1;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_REF1: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_REF;
                        r_cnt   <= LD_RFC;
                        r_state <= S_REF2;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_REF2: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_REF;
                        r_cnt   <= LD_RFC;
                        r_state <= S_MRS;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_MRS: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_MRS;
                        r_ba    <= BA_0;
                        r_addr  <= ADDR_MR_NORMAL;
                        r_cnt   <= LD_MRD;
                        r_state <= S_OCD_DEF;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_OCD_DEF: begin
                    // Waits for both the MRS spacing and the DLL lock time.
                    if (w_cnt_zero && w_dll_zero) begin
                        r_cmd   <= CMD_MRS;
                        r_ba    <= BA_1;
                        r_addr  <= ADDR_EMR_OCDD;
                        r_cnt   <= LD_MRD;
                        r_state <= S_OCD_EXIT;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_OCD_EXIT: begin
                    if (w_cnt_zero) begin
                        r_cmd   <= CMD_MRS;
                        r_ba    <= BA_1;
                        r_addr  <= ADDR_EMR_OCDX;
                        r_cnt   <= LD_MRD;
                        r_state <= S_DONE_WAIT;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_DONE_WAIT: begin
                    if (w_cnt_zero) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cmd <= CMD_NOP;
                    end
                end
                S_DONE: begin
                    r_cke  <= 1'b1;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: fall back to a full restart with the bus deselected.
                    r_cke   <= 1'b0;
                    r_cmd   <= CMD_DESEL;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_dll   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cke       = r_cke;
    assign cs_n      = {CS_W{r_cmd[3]}};
    assign ras_n     = r_cmd[2];
    assign cas_n     = r_cmd[1];
    assign we_n      = r_cmd[0];
    assign ba        = r_ba;
    assign addr      = r_addr;
    assign odt       = r_odt;
    assign init_done = r_done;
    assign init_busy = r_busy;

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Self-checking bench for ddr2_init_seq: scoreboard of expected commands
// (cycle, encoding, ba, addr) built from the timing parameters at reset
// release and compared against the commands observed on the DFI bus.
`timescale 1ns/1ps

`ifndef DRAM_CS_WIDTH
`define DRAM_CS_WIDTH 1
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module tb_ddr2_init_seq;

    localparam int CS_W = `DRAM_CS_WIDTH;
    localparam int BA_W = `DRAM_BA_WIDTH;
    localparam int AW   = `DRAM_ADDR_WIDTH;

    // Instance 0: default timing. 1: long DLL, minimal spacing. 2: T_DLL=1, T_RP=0, T_RFC=6.
    localparam int P0_PW = 40000, P0_NOP = 80, P0_RP = 3, P0_MRD = 2, P0_RFC = 26, P0_DLL = 200;
    localparam int P1_PW = 4,     P1_NOP = 2,  P1_RP = 1, P1_MRD = 1, P1_RFC = 1,  P1_DLL = 200;
    localparam int P2_PW = 4,     P2_NOP = 2,  P2_RP = 0, P2_MRD = 1, P2_RFC = 6,  P2_DLL = 1;

    typedef struct {
        int               cyc;
        logic [3:0]       cmd;
        logic [BA_W-1:0]  ba;
        logic [AW-1:0]    addr;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n_a  [3];
    logic              cke_a    [3];
    logic [CS_W-1:0]   cs_n_a   [3];
    logic              ras_n_a  [3];
    logic              cas_n_a  [3];
    logic              we_n_a   [3];
    logic [BA_W-1:0]   ba_a     [3];
    logic [AW-1:0]     addr_a   [3];
    logic              odt_a    [3];
    logic              done_a   [3];
    logic              busy_a   [3];

    ddr2_init_seq #(.T_PWRUP(P0_PW), .T_NOP(P0_NOP), .T_RP(P0_RP), .T_MRD(P0_MRD), .T_RFC(P0_RFC), .T_DLL(P0_DLL)) u_dut0 (
        .clk(clk), .rst_n(rst_n_a[0]), .cke(cke_a[0]), .cs_n(cs_n_a[0]), .ras_n(ras_n_a[0]), .cas_n(cas_n_a[0]),
        .we_n(we_n_a[0]), .ba(ba_a[0]), .addr(addr_a[0]), .odt(odt_a[0]), .init_done(done_a[0]), .init_busy(busy_a[0]));
    ddr2_init_seq #(.T_PWRUP(P1_PW), .T_NOP(P1_NOP), .T_RP(P1_RP), .T_MRD(P1_MRD), .T_RFC(P1_RFC), .T_DLL(P1_DLL)) u_dut1 (
        .clk(clk), .rst_n(rst_n_a[1]), .cke(cke_a[1]), .cs_n(cs_n_a[1]), .ras_n(ras_n_a[1]), .cas_n(cas_n_a[1]),
        .we_n(we_n_a[1]), .ba(ba_a[1]), .addr(addr_a[1]), .odt(odt_a[1]), .init_done(done_a[1]), .init_busy(busy_a[1]));
    ddr2_init_seq #(.T_PWRUP(P2_PW), .T_NOP(P2_NOP), .T_RP(P2_RP), .T_MRD(P2_MRD), .T_RFC(P2_RFC), .T_DLL(P2_DLL)) u_dut2 (
        .clk(clk), .rst_n(rst_n_a[2]), .cke(cke_a[2]), .cs_n(cs_n_a[2]), .ras_n(ras_n_a[2]), .cas_n(cas_n_a[2]),
        .we_n(we_n_a[2]), .ba(ba_a[2]), .addr(addr_a[2]), .odt(odt_a[2]), .init_done(done_a[2]), .init_busy(busy_a[2]));

    int n_cmp  = 0;
    int n_fail = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  exp_cke, exp_done, exp_dll_gap, exp_ocd_gap;
    int  obs_cke, obs_done, bad_desel, bad_odt, bad_busy, bad_cs;

    function automatic int fix0(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Model: expected command list for a given parameter set.
    task automatic build_expected(input int pw, input int nop, input int rp, input int mrd, input int rfc, input int dll);
        int t, t_dll, t_mrs;
        ev_t e;
`ifdef DDR2_INIT_FAST_SIM_EN
        pw = 16; nop = 4; dll = 8;
`endif
        pw = fix0(pw); nop = fix0(nop); rp = fix0(rp); mrd = fix0(mrd); rfc = fix0(rfc); dll = fix0(dll);
        exp_q.delete();
        exp_cke = pw;
        t = pw + nop;
        e.cyc = t;        e.cmd = 4'b0010; e.ba = BA_W'(0); e.addr = AW'(16'h0400); exp_q.push_back(e);
        t = t + rp;  e.cyc = t; e.cmd = 4'b0000; e.ba = BA_W'(2); e.addr = AW'(16'h0000); exp_q.push_back(e);
        t = t + mrd; e.cyc = t; e.cmd = 4'b0000; e.ba = BA_W'(3); e.addr = AW'(16'h0000); exp_q.push_back(e);
        t = t + mrd; e.cyc = t; e.cmd = 4'b0000; e.ba = BA_W'(1); e.addr = AW'(16'h0004); exp_q.push_back(e);
        t = t + mrd; e.cyc = t; e.cmd = 4'b0000; e.ba = BA_W'(0); e.addr = AW'(16'h0542); exp_q.push_back(e);
        t_dll = t;
        t = t + mrd; e.cyc = t; e.cmd = 4'b0010; e.ba = BA_W'(0); e.addr = AW'(16'h0400); exp_q.push_back(e);
        t = t + rp;  e.cyc = t; e.cmd = 4'b0001; e.ba = BA_W'(0); e.addr = AW'(16'h0000); exp_q.push_back(e);
        t = t + rfc; e.cyc = t; e.cmd = 4'b0001; e.ba = BA_W'(0); e.addr = AW'(16'h0000); exp_q.push_back(e);
        t = t + rfc; e.cyc = t; e.cmd = 4'b0000; e.ba = BA_W'(0); e.addr = AW'(16'h0442); exp_q.push_back(e);
        t_mrs = t;
        t = t + mrd;
        if (t < t_dll + dll) t = t_dll + dll;
        e.cyc = t;   e.cmd = 4'b0000; e.ba = BA_W'(1); e.addr = AW'(16'h0384); exp_q.push_back(e);
        exp_dll_gap = t - t_dll;
        exp_ocd_gap = t - t_mrs;
        t = t + mrd; e.cyc = t; e.cmd = 4'b0000; e.ba = BA_W'(1); e.addr = AW'(16'h0004); exp_q.push_back(e);
        exp_done = t + mrd;
    endtask

    // Observe one instance from cycle 0 (first edge after release) until init_done or budget.
    task automatic collect(input int idx, input int budget);
        ev_t o;
        obs_q.delete();
        obs_cke = -1; obs_done = -1;
        bad_desel = 0; bad_odt = 0; bad_busy = 0; bad_cs = 0;
        for (int c = 0; c < budget && obs_done < 0; c++) begin
            @(negedge clk);
            if (cke_a[idx] === 1'b1 && obs_cke < 0) obs_cke = c;
            if (done_a[idx] === 1'b1) obs_done = c;
            if (cke_a[idx] !== 1'b1 && cs_n_a[idx] !== {CS_W{1'b1}}) bad_desel++;
            if (odt_a[idx] !== 1'b0) bad_odt++;
            if (busy_a[idx] !== ~done_a[idx]) bad_busy++;
            if (cs_n_a[idx] !== {CS_W{cs_n_a[idx][0]}}) bad_cs++;
            if (cs_n_a[idx][0] === 1'b0 && {ras_n_a[idx], cas_n_a[idx], we_n_a[idx]} !== 3'b111) begin
                o.cyc = c; o.cmd = {cs_n_a[idx][0], ras_n_a[idx], cas_n_a[idx], we_n_a[idx]};
                o.ba = ba_a[idx]; o.addr = addr_a[idx];
                obs_q.push_back(o);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) rst_n_a[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({cke_a[i], cs_n_a[i], ras_n_a[i], cas_n_a[i], we_n_a[i]} !== {1'b0, {CS_W{1'b1}}, 3'b111}) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got cke=%b cs_n=%b ras/cas/we=%b%b%b, want cke=0 cs_n=all1 111",
                         i, cke_a[i], cs_n_a[i], ras_n_a[i], cas_n_a[i], we_n_a[i]);
            end
            n_cmp++;
            if ({ba_a[i], addr_a[i], odt_a[i], done_a[i], busy_a[i]} !== '0) begin
                n_fail++;
                $display("FAIL reset_misc[%0d]: got ba=%h addr=%h odt=%b done=%b busy=%b, want all 0",
                         i, ba_a[i], addr_a[i], odt_a[i], done_a[i], busy_a[i]);
            end
        end
    endtask

    task automatic test_init_sequence();
        ev_t e, o;
        int ncmd, ref_gap;
        build_expected(P0_PW, P0_NOP, P0_RP, P0_MRD, P0_RFC, P0_DLL);
        @(negedge clk);
        rst_n_a[0] = 1'b1;
        collect(0, exp_done + 50);
        n_cmp++;
        if (obs_cke !== exp_cke) begin
            n_fail++; $display("FAIL seq_cke_rise: got cycle %0d, want %0d", obs_cke, exp_cke);
        end
        ncmd = obs_q.size();
        n_cmp++;
        if (ncmd !== 11) begin
            n_fail++; $display("FAIL seq_cmd_count: got %0d, want 11", ncmd);
        end
        ref_gap = (ncmd >= 8) ? (obs_q[7].cyc - obs_q[6].cyc) : -1;
        n_cmp++;
        if (ref_gap !== fix0(P0_RFC)) begin
            n_fail++; $display("FAIL seq_ref_gap: got %0d, want %0d", ref_gap, fix0(P0_RFC));
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL seq_cmd%0d: missing, want cyc=%0d cmd=%b ba=%h addr=%h", k, e.cyc, e.cmd, e.ba, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.cmd !== e.cmd || o.ba !== e.ba || o.addr !== e.addr) begin
                    n_fail++;
                    $display("FAIL seq_cmd%0d: got cyc=%0d cmd=%b ba=%h addr=%h, want cyc=%0d cmd=%b ba=%h addr=%h",
                             k, o.cyc, o.cmd, o.ba, o.addr, e.cyc, e.cmd, e.ba, e.addr);
                end
            end
        end
        n_cmp++;
        if (obs_done !== exp_done) begin
            n_fail++; $display("FAIL seq_done: got cycle %0d, want %0d", obs_done, exp_done);
        end
        n_cmp++;
        if ({bad_desel, bad_odt, bad_busy, bad_cs} !== 128'd0) begin
            n_fail++;
            $display("FAIL seq_bus_rules: got desel=%0d odt=%0d busy=%0d cs=%0d bad cycles, want 0 each",
                     bad_desel, bad_odt, bad_busy, bad_cs);
        end
    endtask

    task automatic test_after_done();
        int bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (cs_n_a[0] !== {CS_W{1'b0}} || {ras_n_a[0], cas_n_a[0], we_n_a[0]} !== 3'b111 ||
                cke_a[0] !== 1'b1 || odt_a[0] !== 1'b0 || done_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL after_done_stable: got %0d bad cycles of 1000, want 0", bad);
        end
    endtask

    task automatic test_dll_wait();
        int gap;
        // Long DLL time dominates the intermediate spacing.
        build_expected(P1_PW, P1_NOP, P1_RP, P1_MRD, P1_RFC, P1_DLL);
        @(negedge clk);
        rst_n_a[1] = 1'b1;
        collect(1, exp_done + 50);
        gap = (obs_q.size() >= 11) ? (obs_q[9].cyc - obs_q[4].cyc) : -1;
        n_cmp++;
        if (gap !== exp_dll_gap) begin
            n_fail++; $display("FAIL dll_long_gap: got %0d, want %0d", gap, exp_dll_gap);
        end
        n_cmp++;
        if (obs_done !== exp_done) begin
            n_fail++; $display("FAIL dll_long_done: got cycle %0d, want %0d", obs_done, exp_done);
        end
        // T_DLL=1 (and T_RP=0 clamped to 1): normal MRS spacing.
        build_expected(P2_PW, P2_NOP, P2_RP, P2_MRD, P2_RFC, P2_DLL);
        @(negedge clk);
        rst_n_a[2] = 1'b1;
        collect(2, exp_done + 50);
        gap = (obs_q.size() >= 11) ? (obs_q[9].cyc - obs_q[8].cyc) : -1;
        n_cmp++;
        if (gap !== exp_ocd_gap) begin
            n_fail++; $display("FAIL dll_short_gap: got %0d, want %0d", gap, exp_ocd_gap);
        end
        gap = (obs_q.size() >= 2) ? (obs_q[1].cyc - obs_q[0].cyc) : -1;
        n_cmp++;
        if (gap !== 1) begin
            n_fail++; $display("FAIL trp_zero_gap: got %0d, want 1", gap);
        end
        n_cmp++;
        if (obs_done !== exp_done) begin
            n_fail++; $display("FAIL dll_short_done: got cycle %0d, want %0d", obs_done, exp_done);
        end
    endtask

    task automatic test_reset_mid_sequence();
        int ncmd = 0;
        bit hit = 1'b0;
        rst_n_a[2] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_a[2] = 1'b1;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            if (cs_n_a[2][0] === 1'b0 && {ras_n_a[2], cas_n_a[2], we_n_a[2]} !== 3'b111) begin
                ncmd++;
                if (ncmd == 7) hit = 1'b1;
            end
        end
        n_cmp++;
        if (hit !== 1'b1) begin
            n_fail++; $display("FAIL mid_find_ref1: got %0d commands before timeout, want 7", ncmd);
        end
        @(negedge clk);
        n_cmp++;
        if ({cke_a[2], busy_a[2]} !== 2'b11) begin
            n_fail++; $display("FAIL mid_in_gap: got cke=%b busy=%b, want 1 1", cke_a[2], busy_a[2]);
        end
        #2 rst_n_a[2] = 1'b0;
        #1;
        n_cmp++;
        if ({cke_a[2], cs_n_a[2], ras_n_a[2], cas_n_a[2], we_n_a[2], ba_a[2], addr_a[2], odt_a[2], done_a[2], busy_a[2]}
            !== {1'b0, {CS_W{1'b1}}, 3'b111, {BA_W{1'b0}}, {AW{1'b0}}, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_async_reset: got cke=%b cs_n=%b rcw=%b%b%b ba=%h addr=%h odt=%b done=%b busy=%b, want reset values",
                     cke_a[2], cs_n_a[2], ras_n_a[2], cas_n_a[2], we_n_a[2], ba_a[2], addr_a[2], odt_a[2], done_a[2], busy_a[2]);
        end
        repeat (2) @(negedge clk);
        build_expected(P2_PW, P2_NOP, P2_RP, P2_MRD, P2_RFC, P2_DLL);
        rst_n_a[2] = 1'b1;
        collect(2, exp_done + 50);
        n_cmp++;
        if (obs_cke !== exp_cke) begin
            n_fail++; $display("FAIL mid_rerun_cke: got cycle %0d, want %0d", obs_cke, exp_cke);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL mid_rerun_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (obs_done !== exp_done || bad_desel !== 0) begin
            n_fail++; $display("FAIL mid_rerun_done: got cycle %0d (desel errs %0d), want %0d (0)", obs_done, bad_desel, exp_done);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) rst_n_a[i] = 1'b0;
        test_reset();
        test_init_sequence();
        test_after_done();
        test_dll_wait();
        test_reset_mid_sequence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_init_seq.md
Name: ddr2_init_seq

Overview:
- Power-up initialisation sequencer for the DDR2 memory subsystem.
- Sits directly upstream of the PHY command path and drives the DFI control fields: cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt.
- After reset release it runs the JEDEC DDR2 init sequence autonomously, then asserts init_done. Once init_done is high, the controller owns the DFI control bus.

Parameters:
- T_PWRUP, 40000: cycles CKE held low after reset release (200 us at 200 MHz).
- T_NOP, 80: cycles of NOP between CKE rising and the first PRECHARGE ALL (400 ns).
- T_RP, 3: command-to-command spacing after PRECHARGE ALL.
- T_MRD, 2: command-to-command spacing after MRS/EMRS.
- T_RFC, 26: command-to-command spacing after REFRESH.
- T_DLL, 200: minimum cycles from the DLL-reset MRS to the OCD-default EMRS1.
- MR_VALUE, 13'h0442: MRS address pattern; A8 (DLL reset) is OR'd in by the block where required.
- EMR1_VALUE, 13'h0004: EMRS1 base pattern; A9:A7 are overwritten for OCD.

Ports:
- clk, input, 1: controller clock.
- rst_n, input, 1: asynchronous active-low reset.
- cke, output, 1: clock enable.
- cs_n, output, `DRAM_CS_WIDTH: chip selects; all ranks are driven identically.
- ras_n, output, 1: row address strobe.
- cas_n, output, 1: column address strobe.
- we_n, output, 1: write enable.
- ba, output, `DRAM_BA_WIDTH: bank address.
- addr, output, `DRAM_ADDR_WIDTH: address.
- odt, output, 1: on-die termination; held 0 for the whole sequence.
- init_done, output, 1: high once the sequence is complete.
- init_busy, output, 1: high from reset release until init_done rises.

Behaviour:
- Reset values: cke=0, cs_n=all 1, ras_n=cas_n=we_n=1, ba=0, addr=0, odt=0, init_done=0, init_busy=0.
  - Asserting rst_n low at any point forces these values asynchronously.
  - After release, the sequence restarts from WAIT_PWRUP.
- Timing: all outputs are registered on posedge clk; the half-cycle alignment is done downstream.
- Command encodings (cs_n, ras_n, cas_n, we_n):
  - DESELECT = 1xxx.
  - NOP = 0111.
  - PRE = 0010, with addr[10]=1 (PRECHARGE ALL).
  - REF = 0001.
  - MRS/EMRS = 0000.
- Every command is driven for exactly one cycle. All other cycles are NOP, except the cke=0 phase, which is DESELECT.
- A single down-counter provides spacing. If a command issues at cycle n, the next command issues at cycle n+T_x, where T_x is the parameter of the preceding command.
- State order (ba / addr shown for mode-register writes):
  1. WAIT_PWRUP: DESELECT and cke=0 for T_PWRUP cycles. init_busy=1 from the first cycle after reset release.
  2. CKE_HIGH: cke=1 and NOP for T_NOP cycles.
  3. PRE1.
  4. EMRS2: ba=2, addr=0.
  5. EMRS3: ba=3, addr=0.
  6. EMRS1: ba=1, addr=EMR1_VALUE & ~A9:A7.
  7. MRS_DLLRST: ba=0, addr=MR_VALUE | A8. This command also loads the DLL counter with T_DLL.
  8. PRE2.
  9. REF1.
  10. REF2.
  11. MRS: ba=0, addr=MR_VALUE & ~A8.
  12. EMRS1_OCD_DEF: A9:A7=3'b111. Issues only once both the spacing counter and the DLL counter have expired.
  13. EMRS1_OCD_EXIT: A9:A7=3'b000.
  14. DONE.
- The DONE state is entered T_MRD cycles after EMRS1_OCD_EXIT. In DONE: init_done=1, init_busy=0, outputs held at NOP with cke=1, odt=0, until reset.
- A parameter value of 0 is treated as 1 (minimum spacing is one cycle).
- The DLL counter saturates at 0. If T_DLL is already covered by the intermediate spacing, no extra wait is added.

Optional Feature:
- Macro DDR2_INIT_FAST_SIM_EN.
  - Defined: the effective T_PWRUP is 16, the effective T_NOP is 4, and the effective T_DLL is 8. All other timing is unchanged.
  - Undefined: the parameter values are used as given.

Test Plan:
- Default parameters, release rst_n at cycle 0:
  - cke rises at cycle 40000.
  - PRE1 appears at cycle 40080.
  - Exactly 11 non-NOP commands appear, in the listed order, with the listed ba/addr values.
  - init_done rises T_MRD cycles after the last command.
- Spacing check: measured command-to-command gaps equal T_RP, T_MRD and T_RFC exactly. Both REF commands are separated by 26 cycles.
- T_DLL=200 with all other spacings minimal: EMRS1_OCD_DEF issues exactly 200 cycles after MRS_DLLRST. With T_DLL=1, it issues at the normal T_MRD spacing.
- Reset mid-sequence: assert rst_n low between REF1 and REF2.
  - All outputs return to reset values within the same cycle.
  - After release, cke stays 0 for the full T_PWRUP and the whole sequence reruns.
- With DDR2_INIT_FAST_SIM_EN defined: cke rises at cycle 16, PRE1 appears at cycle 20, and init_done rises well before cycle 200.
- After init_done: for 1000 cycles, cs_n=0, ras_n=cas_n=we_n=1, cke=1 and odt=0 remain stable.
